// File: rtl/apb_sfr_pkg.sv
// Shared types and constants for the APB-to-SFR bridge: FSM states, SFR map
// and the address decode helper.
package apb_sfr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] SFR_CTRL_ADDR     = 32'h0000_0000;
    localparam logic [31:0] SFR_INTR_STS_ADDR = 32'h0000_0004;
    localparam logic [31:0] SFR_INTR_MSK_ADDR = 32'h0000_0008;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Word-aligned and inside the implemented SFR window.
    function automatic logic addr_decode_ok(input logic [31:0] addr,
                                            input logic [31:0] last_addr);
        return (addr[1:0] == 2'b00) && (addr <= last_addr);
    endfunction

endpackage

// File: rtl/apb_sfr_bridge_if.sv
// APB3/4 bus bundle between an APB master and the SFR bridge slave.
interface apb_sfr_bridge_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_sfr_bridge.sv
// APB slave that turns one APB transfer at a time into a single-cycle SFR
// strobe, waits for the SFR handshake with a timeout, and returns the response.
module apb_sfr_bridge
    import apb_sfr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] LAST_ADDR      = SFR_INTR_MSK_ADDR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    apb_sfr_bridge_if.slave      apb,
    output logic                 sfr_wr_en,
    output logic                 sfr_rd_en,
    output logic [31:0]          sfr_waddr,
    output logic [31:0]          sfr_raddr,
    output logic [31:0]          sfr_wdata,
    output logic [3:0]           sfr_wstrobe,
    input  logic [31:0]          sfr_rdata,
    input  logic                 sfr_wready,
    input  logic                 sfr_rvalid
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e      state_r;
    state_e      state_s;
    logic [7:0]  cnt_r;
    logic        write_r;
    logic        abort_r;
    logic        pready_r;
    logic        pslverr_r;
    logic [31:0] prdata_r;
    logic        sfr_wr_en_r;
    logic        sfr_rd_en_r;
    logic [31:0] sfr_waddr_r;
    logic [31:0] sfr_raddr_r;
    logic [31:0] sfr_wdata_r;
    logic [3:0]  sfr_wstrobe_r;

    logic setup_s;
    logic decode_ok_s;
    logic done_s;
    logic timeout_s;
    logic keep_pready_s;

    assign setup_s       = apb.psel && !apb.penable;
    assign decode_ok_s   = addr_decode_ok(apb.paddr, LAST_ADDR);
    // Handshakes only count for the direction actually in flight.
    assign done_s        = write_r ? sfr_wready : sfr_rvalid;
    assign timeout_s     = (cnt_r == TIMEOUT_LIMIT);
    assign keep_pready_s = !abort_r && apb.psel;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; completion takes priority over timeout in WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    state_s = decode_ok_s ? ST_ISSUE : ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (done_s || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Registered datapath: request latch, SFR strobes, wait counter, APB response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r         <= 8'd0;
            write_r       <= 1'b0;
            abort_r       <= 1'b0;
            pready_r      <= 1'b0;
            pslverr_r     <= 1'b0;
            prdata_r      <= 32'd0;
            sfr_wr_en_r   <= 1'b0;
            sfr_rd_en_r   <= 1'b0;
            sfr_waddr_r   <= 32'd0;
            sfr_raddr_r   <= 32'd0;
            sfr_wdata_r   <= 32'd0;
            sfr_wstrobe_r <= 4'd0;
        end else begin
            sfr_wr_en_r <= 1'b0;
            sfr_rd_en_r <= 1'b0;
            pready_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        abort_r <= 1'b0;
                        if (decode_ok_s) begin
                            write_r       <= apb.pwrite;
                            sfr_waddr_r   <= apb.paddr;
                            sfr_raddr_r   <= apb.paddr;
                            sfr_wdata_r   <= apb.pwrite ? apb.pwdata : 32'd0;
                            sfr_wstrobe_r <= apb.pwrite ? apb.pstrb : 4'd0;
                            sfr_wr_en_r   <= apb.pwrite;
                            sfr_rd_en_r   <= !apb.pwrite;
                        end else begin
                            pready_r  <= 1'b1;
                            pslverr_r <= 1'b1;
                            prdata_r  <= 32'd0;
                        end
                    end else begin
                        abort_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= 8'd0;
                    if (!apb.psel) begin
                        abort_r <= 1'b1;
                    end else begin
                        abort_r <= abort_r;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (!apb.psel) begin
                        abort_r <= 1'b1;
                    end else begin
                        abort_r <= abort_r;
                    end
                    if (done_s) begin
                        pready_r  <= keep_pready_s;
                        pslverr_r <= 1'b0;
                        prdata_r  <= write_r ? 32'd0 : sfr_rdata;
                    end else if (timeout_s) begin
                        pready_r  <= keep_pready_s;
                        pslverr_r <= 1'b1;
                        prdata_r  <= 32'd0;
                    end else begin
                        pready_r  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 8'd0;
                end
            endcase
        end
    end

    assign apb.pready   = pready_r;
    assign apb.pslverr  = pslverr_r;
    assign apb.prdata   = prdata_r;
    assign sfr_wr_en    = sfr_wr_en_r;
    assign sfr_rd_en    = sfr_rd_en_r;
    assign sfr_waddr    = sfr_waddr_r;
    assign sfr_raddr    = sfr_raddr_r;
    assign sfr_wdata    = sfr_wdata_r;
    assign sfr_wstrobe  = sfr_wstrobe_r;

endmodule

// File: tb/tb_apb_sfr_bridge.sv
// Randomized self-checking bench for apb_sfr_bridge with an SFR device model
// and a transaction-level reference model of the expected APB responses.
module tb_apb_sfr_bridge;

    localparam int          T    = 6;
    localparam logic [31:0] LAST = 32'h8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    apb_sfr_bridge_if bus();

    logic        sfr_wr_en, sfr_rd_en;
    logic [31:0] sfr_waddr, sfr_raddr, sfr_wdata;
    logic [3:0]  sfr_wstrobe;
    logic [31:0] sfr_rdata  = 32'd0;
    logic        sfr_wready = 1'b0;
    logic        sfr_rvalid = 1'b0;

    apb_sfr_bridge #(.TIMEOUT_CYCLES(T), .LAST_ADDR(LAST)) dut (
        .clk(clk), .reset_n(reset_n), .apb(bus),
        .sfr_wr_en(sfr_wr_en), .sfr_rd_en(sfr_rd_en),
        .sfr_waddr(sfr_waddr), .sfr_raddr(sfr_raddr),
        .sfr_wdata(sfr_wdata), .sfr_wstrobe(sfr_wstrobe),
        .sfr_rdata(sfr_rdata), .sfr_wready(sfr_wready), .sfr_rvalid(sfr_rvalid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int resp_dly = 0;      // device response delay in cycles after the strobe; <0 = never
    bit last_tmo = 1'b0;

    logic [31:0] dev_mem [4] = '{32'd5, 32'd0, 32'd0, 32'd0};
    logic [31:0] ref_mem [4] = '{32'd5, 32'd0, 32'd0, 32'd0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // SFR device: stores writes, answers each strobe after resp_dly cycles.
    logic       pend = 1'b0;
    logic       pend_wr = 1'b0;
    int         pend_ctr = 0;
    logic [1:0] pend_idx = 2'd0;
    always @(posedge clk) begin
        sfr_wready <= 1'b0;
        sfr_rvalid <= 1'b0;
        if (pend && pend_ctr == 0) begin
            pend <= 1'b0;
            if (pend_wr) sfr_wready <= 1'b1;
            else begin
                sfr_rvalid <= 1'b1;
                sfr_rdata  <= dev_mem[pend_idx];
            end
        end else if (pend) begin
            pend_ctr <= pend_ctr - 1;
        end
        if (sfr_wr_en || sfr_rd_en) begin
            if (sfr_wr_en) dev_mem[sfr_waddr[3:2]] <= merge(dev_mem[sfr_waddr[3:2]], sfr_wdata, sfr_wstrobe);
            if (resp_dly == 0) begin
                if (sfr_wr_en) sfr_wready <= 1'b1;
                else begin
                    sfr_rvalid <= 1'b1;
                    sfr_rdata  <= dev_mem[sfr_raddr[3:2]];
                end
            end else if (resp_dly > 0) begin
                pend     <= 1'b1;
                pend_ctr <= resp_dly - 1;
                pend_wr  <= sfr_wr_en;
                pend_idx <= sfr_raddr[3:2];
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.psel = 1'b0;
            bus.penable = 1'b0;
            check_eq("idle_pready", {31'd0, bus.pready}, 32'd0);
        end
    endtask

    // One APB transfer; expected latency/response derived from the bridge rules.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int dly);
        int cyc, nwr, nrd, exp_lat;
        bit got, ok, tmo;
        logic [31:0] exp_rd, cap_addr, cap_wdata;
        logic [3:0]  cap_strb;
        ok  = (addr[1:0] == 2'b00) && (addr <= LAST);
        tmo = ok && (dly < 0 || dly > T);
        exp_lat = !ok ? 1 : (tmo ? 3 + T : 3 + dly);
        exp_rd  = (!ok || wr || tmo) ? 32'd0 : ref_mem[addr[3:2]];
        if (ok && wr) ref_mem[addr[3:2]] = merge(ref_mem[addr[3:2]], data, strb);
        last_tmo = tmo;
        cap_addr = 32'd0; cap_wdata = 32'd0; cap_strb = 4'd0;
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb;
        resp_dly = dly;
        @(negedge clk);
        bus.penable = 1'b1;
        cyc = 1; nwr = 0; nrd = 0; got = 1'b0;
        while (!got && cyc <= T + 8) begin
            if (sfr_wr_en) begin
                nwr++; cap_addr = sfr_waddr; cap_wdata = sfr_wdata; cap_strb = sfr_wstrobe;
            end
            if (sfr_rd_en) begin
                nrd++; cap_addr = sfr_raddr; cap_strb = sfr_wstrobe;
            end
            if (bus.pready) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("pready_seen", {31'd0, got}, 32'd1);
        check_eq("latency", cyc, exp_lat);
        check_eq("pslverr", {31'd0, bus.pslverr}, {31'd0, (!ok || tmo)});
        check_eq("prdata", bus.prdata, exp_rd);
        check_eq("wr_strobes", nwr, (ok && wr) ? 1 : 0);
        check_eq("rd_strobes", nrd, (ok && !wr) ? 1 : 0);
        if (ok) begin
            check_eq("sfr_addr", cap_addr, addr);
            check_eq("sfr_wstrobe", {28'd0, cap_strb}, wr ? {28'd0, strb} : 32'd0);
            if (wr) check_eq("sfr_wdata", cap_wdata, data);
        end
    endtask

    logic [31:0] addr_tab [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h2, 32'h1, 32'h100, 32'hFFFF_FFFC};

    initial begin
        int seen;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 32'd0; bus.pwdata = 32'd0; bus.pstrb = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_pready", {31'd0, bus.pready}, 32'd0);
        check_eq("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        check_eq("rst_prdata", bus.prdata, 32'd0);
        check_eq("rst_wr_en", {31'd0, sfr_wr_en}, 32'd0);
        check_eq("rst_rd_en", {31'd0, sfr_rd_en}, 32'd0);
        check_eq("rst_waddr", sfr_waddr, 32'd0);
        check_eq("rst_raddr", sfr_raddr, 32'd0);
        check_eq("rst_wdata", sfr_wdata, 32'd0);
        check_eq("rst_wstrobe", {28'd0, sfr_wstrobe}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        apb_xfer(1'b0, 32'h0, 32'd0, 4'h0, 0);                  // read CTRL -> 5
        idle(1);
        apb_xfer(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0);          // T0..T3 write
        idle(1);
        apb_xfer(1'b0, 32'hC, 32'd0, 4'h0, 0);                  // out of range
        apb_xfer(1'b1, 32'h2, 32'h1234_5678, 4'hF, 0);          // misaligned
        idle(1);
        apb_xfer(1'b1, 32'h4, 32'hA5A5_0F0F, 4'hF, T + 2);      // timeout, late wready
        idle(6);
        apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, 1);
        idle(1);

        // Reset during WAIT of a read; the device answers after reset.
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h4;
        resp_dly = 3;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        check_eq("mid_rst_pready", {31'd0, bus.pready}, 32'd0);
        check_eq("mid_rst_raddr", sfr_raddr, 32'd0);
        idle(8);
        apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, 2);

        // Back-to-back: write then read accepted in the first IDLE cycle.
        apb_xfer(1'b1, 32'h0, 32'h7, 4'hF, 0);
        apb_xfer(1'b0, 32'h0, 32'd0, 4'h0, 0);
        idle(1);

        // psel dropped mid-transfer: SFR write still happens, no pready.
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h8; bus.pwdata = 32'h0BAD_F00D; bus.pstrb = 4'h3;
        resp_dly = 2;
        ref_mem[2] = merge(ref_mem[2], 32'h0BAD_F00D, 4'h3);
        @(negedge clk);
        bus.penable = 1'b1;
        check_eq("abort_wr_en", {31'd0, sfr_wr_en}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.psel = 1'b0; bus.penable = 1'b0;
            if (bus.pready) seen++;
        end
        check_eq("abort_no_pready", seen, 0);
        apb_xfer(1'b0, 32'h8, 32'd0, 4'h0, 0);

        for (int n = 0; n < 40; n++) begin
            apb_xfer(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 7)], $urandom,
                     4'($urandom_range(0, 15)), int'($urandom_range(0, T + 3)));
            if (last_tmo) idle(6);
            else idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_sfr_bridge.md
APB_SFR_BRIDGE -- requirements
Module: apb_sfr_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 16, max WAIT cycles before error response (range 2..255).
REQ-002 SHALL have parameter LAST_ADDR, 32'h8, highest valid word-aligned SFR address.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have APB slave ports: psel in 1, penable in 1, pwrite in 1, paddr in 32, pwdata in 32, pstrb in 4, prdata out 32, pready out 1, pslverr out 1.
REQ-006 SHALL have SFR master ports: sfr_wr_en out 1, sfr_rd_en out 1, sfr_waddr out 32, sfr_raddr out 32, sfr_wdata out 32, sfr_wstrobe out 4, sfr_rdata in 32, sfr_wready in 1, sfr_rvalid in 1.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-008 In IDLE, when psel=1 and penable=0 (setup phase), SHALL latch paddr, pwdata, pstrb, pwrite.
REQ-009 Decode error: paddr[1:0]!=0 or paddr>LAST_ADDR. SHALL go IDLE->RESP with pslverr=1 and prdata=0, with no SFR strobe.
REQ-010 A valid setup SHALL go IDLE->ISSUE.
REQ-011 In ISSUE, SHALL assert exactly one of sfr_wr_en or sfr_rd_en for exactly one cycle, then go ISSUE->WAIT.
REQ-012 sfr_waddr/sfr_raddr SHALL carry the latched address, held stable from ISSUE until back in IDLE.
REQ-013 sfr_wdata and sfr_wstrobe SHALL carry the latched pwdata and pstrb on writes; sfr_wstrobe SHALL be 0 on reads.
REQ-014 In WAIT, a write SHALL complete on sfr_wready=1 and a read on sfr_rvalid=1; a read SHALL capture sfr_rdata into prdata in that same cycle; both SHALL go WAIT->RESP with pslverr=0.
REQ-015 WAIT counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-016 Timeout: when the counter reaches TIMEOUT_CYCLES without completion, SHALL go WAIT->RESP with pslverr=1 and prdata=0.
REQ-017 Completion and timeout in the same cycle: completion SHALL win.
REQ-018 In RESP, SHALL drive pready=1 for exactly one cycle, then go RESP->IDLE; pready SHALL be 0 in every other state.
REQ-019 prdata and pslverr SHALL be registered and hold until the next RESP; prdata SHALL be 0 on write responses.
REQ-020 Write latency SHALL be setup at T0, sfr_wr_en at T1, sfr_wready sampled at T2, pready at T3, given a one-cycle-registered sfr_wready; reads SHALL match this.
REQ-021 sfr_wready/sfr_rvalid arriving outside WAIT (late, after timeout, or stale) SHALL be ignored.
REQ-022 If psel drops before RESP, SHALL finish the SFR access, suppress pready, and return to IDLE.
REQ-023 A setup arriving during ISSUE/WAIT/RESP SHALL NOT be accepted; only one transfer is outstanding.
REQ-024 IDLE->IDLE back-to-back: a new setup SHALL be accepted the first IDLE cycle after RESP.

Reset
REQ-025 When reset_n=0 at a clock edge, SHALL enter IDLE and set pready=0, pslverr=0, prdata=0, sfr_wr_en=0, sfr_rd_en=0, sfr_waddr=0, sfr_raddr=0, sfr_wdata=0, sfr_wstrobe=0, counter=0.
REQ-026 Reset mid-transfer SHALL abort it with no pready pulse; in-flight SFR responses SHALL be ignored.

Structure
REQ-027 Package apb_sfr_pkg SHALL hold the state enum, the SFR address constants (CTRL 'h0, INTR_STS 'h4, INTR_MSK 'h8), and the default TIMEOUT_CYCLES.
REQ-028 SHALL be a single module with no sub-module; the decode and counter are inline.

Verification
REQ-029 APB write 0x8 data 0xDEADBEEF pstrb 4'hF -> sfr_wr_en at T1 with waddr 0x8, wstrobe 4'hF; pready at T3; pslverr=0.
REQ-030 APB read 0x0 after reset, SFR returns 5 -> sfr_rd_en one cycle; prdata=0x5; pslverr=0.
REQ-031 APB read 0xC, then write 0x2 -> pslverr=1, prdata=0, no SFR strobe, both times.
REQ-032 Write 0x4 with sfr_wready tied 0 -> pready 1+TIMEOUT_CYCLES+1 cycles after ISSUE, pslverr=1; a later sfr_wready pulse ignored.
REQ-033 reset_n=0 during WAIT of read 0x4 -> IDLE, no pready; next read 0x4 completes normally.
REQ-034 Back-to-back write 0x0 = 0x7 then read 0x0 -> second setup accepted in IDLE after first RESP; prdata=0x7.
